// File: rtl/seq_mult_param.sv
// Shift-add sequential multiplier: retires one multiplier bit per cycle behind a start/busy/done handshake.
// Define SEQ_MULT_SIGNED_EN to honour signed_i (two's-complement operands); otherwise all operations are unsigned.
module seq_mult_param #(
  parameter int WIDTH = 32
) (
  input  logic               clk_i,
  input  logic               rst_n_i,
  input  logic               start_i,
  input  logic               signed_i,
  input  logic [WIDTH-1:0]   md_i,
  input  logic [WIDTH-1:0]   mr_i,
  output logic               busy_o,
  output logic               done_o,
  output logic [2*WIDTH-1:0] product_o
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;

  state_t state, state_nxt;

  logic [WIDTH-1:0]   acc_hi;
  logic [WIDTH-1:0]   mr_sh;
  logic [WIDTH-1:0]   md_hold;
  logic [CNT_W-1:0]   cnt;
  logic               load;
  logic               last;
  logic [WIDTH:0]     sum;
  logic [2*WIDTH-1:0] shifted;
  logic [2*WIDTH-1:0] result;
  logic [WIDTH-1:0]   md_load;
  logic [WIDTH-1:0]   mr_load;

  assign last = (cnt == CNT_LAST);

  // The carry lands in the top bit of acc_hi once {carry, sum, mr_sh} is shifted right by one.
  assign sum     = {1'b0, acc_hi} + (mr_sh[0] ? {1'b0, md_hold} : '0);
  assign shifted = {sum, mr_sh[WIDTH-1:1]};

`ifdef SEQ_MULT_SIGNED_EN
  logic neg;
  logic neg_load;

  // -2^(WIDTH-1) negates to itself, which is exactly its unsigned magnitude.
  always_comb begin
    md_load  = md_i;
    mr_load  = mr_i;
    neg_load = 1'b0;
    if (signed_i) begin
      md_load  = md_i[WIDTH-1] ? (~md_i + WIDTH'(1)) : md_i;
      mr_load  = mr_i[WIDTH-1] ? (~mr_i + WIDTH'(1)) : mr_i;
      neg_load = md_i[WIDTH-1] ^ mr_i[WIDTH-1];
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      neg <= 1'b0;
    end else if (load) begin
      neg <= neg_load;
    end
  end

  assign result = neg ? (~shifted + (2*WIDTH)'(1)) : shifted;
`else
  logic unused_signed;

  assign unused_signed = signed_i;
  assign md_load       = md_i;
  assign mr_load       = mr_i;
  assign result        = shifted;
`endif

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = IDLE;
    load      = 1'b0;
    busy_o    = 1'b0;
    done_o    = 1'b0;
    case (state)
      IDLE: begin
        if (start_i) begin
          load      = 1'b1;
          state_nxt = RUN;
        end
      end
      RUN: begin
        busy_o    = 1'b1;
        state_nxt = last ? DONE : RUN;
      end
      DONE: begin
        done_o = 1'b1;
        if (start_i) begin
          load      = 1'b1;
          state_nxt = RUN;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // product_o only moves on the edge that leaves RUN, so it holds between completions.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      acc_hi    <= '0;
      mr_sh     <= '0;
      md_hold   <= '0;
      cnt       <= '0;
      product_o <= '0;
    end else if (load) begin
      acc_hi  <= '0;
      mr_sh   <= mr_load;
      md_hold <= md_load;
      cnt     <= '0;
    end else if (state == RUN) begin
      acc_hi <= shifted[2*WIDTH-1:WIDTH];
      mr_sh  <= shifted[WIDTH-1:0];
      if (last) begin
        product_o <= result;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_seq_mult_param.sv
// Directed bench for seq_mult_param with WIDTH=8 and WIDTH=32 instances and hand-computed products.
// Signed-mode expectations switch on SEQ_MULT_SIGNED_EN.
module tb_seq_mult_param;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n8, start8, signed8;
  logic [7:0]  md8, mr8;
  logic        busy8, done8;
  logic [15:0] product8;

  logic        rst_n32, start32, signed32;
  logic [31:0] md32, mr32;
  logic        busy32, done32;
  logic [63:0] product32;

  int checks = 0;
  int errors = 0;

  seq_mult_param #(.WIDTH(8)) u_mult8 (
    .clk_i     (clk),
    .rst_n_i   (rst_n8),
    .start_i   (start8),
    .signed_i  (signed8),
    .md_i      (md8),
    .mr_i      (mr8),
    .busy_o    (busy8),
    .done_o    (done8),
    .product_o (product8)
  );

  seq_mult_param #(.WIDTH(32)) u_mult32 (
    .clk_i     (clk),
    .rst_n_i   (rst_n32),
    .start_i   (start32),
    .signed_i  (signed32),
    .md_i      (md32),
    .mr_i      (mr32),
    .busy_o    (busy32),
    .done_o    (done32),
    .product_o (product32)
  );

  task automatic check_output(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    assert (observed === expected)
      else begin
        errors++;
        $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
      end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drive operands with start high across one edge; returns in cycle T+1.
  task automatic apply_stimulus(input bit wide, input logic [31:0] md, input logic [31:0] mr, input logic sgn);
    if (wide) begin
      md32 = md; mr32 = mr; signed32 = sgn; start32 = 1'b1;
    end else begin
      md8 = md[7:0]; mr8 = mr[7:0]; signed8 = sgn; start8 = 1'b1;
    end
    step();
    start8  = 1'b0;
    start32 = 1'b0;
  endtask

  // Checks busy through T+1..T+WIDTH, then done and product in T+WIDTH+1; optionally pokes start mid-run.
  task automatic wait_done(input string tag, input bit wide, input logic [63:0] exp, input int poke);
    int n;
    n = wide ? 32 : 8;
    for (int k = 1; k <= n; k++) begin
      check_output({tag, " busy"}, wide ? {62'd0, busy32, done32} : {62'd0, busy8, done8}, 64'd2);
      if (k == poke) begin
        start8 = 1'b1; md8 = 8'h11; mr8 = 8'h22; signed8 = 1'b0;
      end
      step();
      start8 = 1'b0;
    end
    check_output({tag, " done"}, wide ? {62'd0, busy32, done32} : {62'd0, busy8, done8}, 64'd1);
    check_output({tag, " product"}, wide ? product32 : {48'd0, product8}, exp);
  endtask

  initial begin
    rst_n8 = 1'b0; start8 = 1'b0; signed8 = 1'b0; md8 = '0; mr8 = '0;
    rst_n32 = 1'b0; start32 = 1'b0; signed32 = 1'b0; md32 = '0; mr32 = '0;
    #12;
    check_output("reset8 busy/done", {62'd0, busy8, done8}, 64'd0);
    check_output("reset8 product", {48'd0, product8}, 64'd0);
    check_output("reset32 busy/done", {62'd0, busy32, done32}, 64'd0);
    check_output("reset32 product", product32, 64'd0);
    step();
    rst_n8 = 1'b1; rst_n32 = 1'b1;
    step();
    check_output("idle8 after reset", {62'd0, busy8, done8}, 64'd0);

    apply_stimulus(1'b0, 32'd3, 32'd5, 1'b0);
    wait_done("u 3x5", 1'b0, 64'h000F, 0);
    step();
    check_output("u 3x5 done pulse", {62'd0, busy8, done8}, 64'd0);
    check_output("u 3x5 product hold", {48'd0, product8}, 64'h000F);

    apply_stimulus(1'b0, 32'hFF, 32'hFF, 1'b0);
    wait_done("u FFxFF", 1'b0, 64'hFE01, 0);
    step();

    apply_stimulus(1'b0, 32'h00, 32'hA5, 1'b0);
    wait_done("u 0xA5", 1'b0, 64'h0000, 0);
    step();

`ifdef SEQ_MULT_SIGNED_EN
    apply_stimulus(1'b0, 32'hFD, 32'h05, 1'b1);
    wait_done("s -3x5", 1'b0, 64'hFFF1, 0);
    step();
    apply_stimulus(1'b0, 32'h80, 32'h80, 1'b1);
    wait_done("s 80x80", 1'b0, 64'h4000, 0);
    step();
    apply_stimulus(1'b0, 32'h80, 32'h01, 1'b1);
    wait_done("s 80x01", 1'b0, 64'hFF80, 0);
    step();
`else
    apply_stimulus(1'b0, 32'hFD, 32'h05, 1'b1);
    wait_done("s-off FDx5", 1'b0, 64'h04F1, 0);
    step();
    apply_stimulus(1'b0, 32'h80, 32'h80, 1'b1);
    wait_done("s-off 80x80", 1'b0, 64'h4000, 0);
    step();
    apply_stimulus(1'b0, 32'h80, 32'h01, 1'b1);
    wait_done("s-off 80x01", 1'b0, 64'h0080, 0);
    step();
`endif

    // Start poked at T+3 must not disturb 7x9; the second op starts from the DONE cycle.
    apply_stimulus(1'b0, 32'd7, 32'd9, 1'b0);
    wait_done("ignore start 7x9", 1'b0, 64'h003F, 3);
    apply_stimulus(1'b0, 32'h0C, 32'h0B, 1'b0);
    wait_done("b2b 12x11", 1'b0, 64'h0084, 0);
    step();
    check_output("b2b idle", {62'd0, busy8, done8}, 64'd0);

    apply_stimulus(1'b1, 32'h10, 32'h10, 1'b0);
    wait_done("w32 10x10", 1'b1, 64'h100, 0);
    step();

    apply_stimulus(1'b1, 32'hFFFF, 32'hFFFF, 1'b0);
    for (int k = 1; k < 10; k++) step();
    check_output("w32 busy before abort", {62'd0, busy32, done32}, 64'd2);
    #2;
    rst_n32 = 1'b0;
    #1;
    check_output("w32 abort busy/done", {62'd0, busy32, done32}, 64'd0);
    check_output("w32 abort product", product32, 64'd0);
    step();
    rst_n32 = 1'b1;
    step();
    check_output("w32 idle after abort", {62'd0, busy32, done32}, 64'd0);

    apply_stimulus(1'b1, 32'hFFFF_FFFF, 32'd2, 1'b0);
    wait_done("w32 FFFFFFFFx2", 1'b1, 64'h1_FFFF_FFFE, 0);
    step();
    check_output("w32 final idle", {62'd0, busy32, done32}, 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
